// File: rtl/fft_spi_packetizer.sv
// Streams one finished FFT frame as bytes: 0xA5 header, BFP exponent, one saturated
// |re|+|im| magnitude byte per bin for the lower half spectrum, then an XOR checksum.
module fft_spi_packetizer #(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int FFT_N      = $clog2(FFT_LENGTH),
    parameter int DMA_LAT    = 2,
    parameter int MAG_SHIFT  = 8
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     rst,
    input  logic                     fft_done_i,
    input  logic signed [7:0]        bfpexp_i,
    output logic                     dmaact_o,
    output logic [FFT_N-1:0]         dmaa_o,
    input  logic signed [FFT_DW-1:0] dmadr_real_i,
    input  logic signed [FFT_DW-1:0] dmadr_imag_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     busy_o,
    output logic                     overrun_o,
    output logic [7:0]               frame_cnt_o
);
    localparam logic [FFT_N-1:0] LAST_BIN = FFT_N'(FFT_LENGTH / 2 - 1);
    localparam int WW = (DMA_LAT > 1) ? $clog2(DMA_LAT) : 1;

    typedef enum logic [2:0] {IDLE, HDR, EXP, RDREQ, RDWAIT, SEND, CSUM} state_t;

    state_t          state;
    logic [7:0]      exp_q;
    logic [7:0]      csum;
    logic [WW-1:0]   wcnt;
    logic [FFT_DW-1:0] abs_re, abs_im;
    logic [FFT_DW:0]   mag, mag_sh;
    logic [7:0]        mag_byte;
    logic              accept;

    // One extra bit keeps |-2^(DW-1)| exact and the sum from wrapping.
    always_comb begin
        abs_re   = dmadr_real_i[FFT_DW-1] ? (~$unsigned(dmadr_real_i) + FFT_DW'(1)) : $unsigned(dmadr_real_i);
        abs_im   = dmadr_imag_i[FFT_DW-1] ? (~$unsigned(dmadr_imag_i) + FFT_DW'(1)) : $unsigned(dmadr_imag_i);
        mag      = {1'b0, abs_re} + {1'b0, abs_im};
        mag_sh   = mag >> MAG_SHIFT;
        mag_byte = (|mag_sh[FFT_DW:8]) ? 8'hFF : mag_sh[7:0];
    end

    assign accept = tx_valid_o && tx_ready_i;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            exp_q       <= 8'h00;
            csum        <= 8'h00;
            wcnt        <= '0;
            dmaact_o    <= 1'b0;
            dmaa_o      <= '0;
            tx_data_o   <= 8'h00;
            tx_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 1'b0;
            frame_cnt_o <= 8'h00;
        end else begin
            if (fft_done_i && state != IDLE)
                overrun_o <= 1'b1;
            unique case (state)
                IDLE: if (fft_done_i) begin
                    exp_q      <= bfpexp_i;
                    csum       <= 8'h00;
                    tx_data_o  <= 8'hA5;
                    tx_valid_o <= 1'b1;
                    busy_o     <= 1'b1;
                    state      <= HDR;
                end
                // Exponent is already known, so it follows the header back-to-back.
                HDR: if (accept) begin
                    csum      <= csum ^ tx_data_o;
                    tx_data_o <= exp_q;
                    state     <= EXP;
                end
                EXP: if (accept) begin
                    csum       <= csum ^ tx_data_o;
                    tx_valid_o <= 1'b0;
                    dmaact_o   <= 1'b1;
                    dmaa_o     <= '0;
                    state      <= RDREQ;
                end
                RDREQ: begin
                    dmaact_o <= 1'b0;
                    wcnt     <= WW'(DMA_LAT - 1);
                    state    <= RDWAIT;
                end
                RDWAIT: begin
                    if (wcnt == '0) begin
                        tx_data_o  <= mag_byte;
                        tx_valid_o <= 1'b1;
                        state      <= SEND;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                SEND: if (accept) begin
                    csum       <= csum ^ tx_data_o;
                    tx_valid_o <= 1'b0;
                    if (dmaa_o == LAST_BIN) begin
                        state <= CSUM;
                    end else begin
                        dmaa_o   <= dmaa_o + FFT_N'(1);
                        dmaact_o <= 1'b1;
                        state    <= RDREQ;
                    end
                end
                CSUM: begin
                    if (!tx_valid_o) begin
                        tx_data_o  <= csum;
                        tx_valid_o <= 1'b1;
                    end else if (tx_ready_i) begin
                        tx_valid_o  <= 1'b0;
                        busy_o      <= 1'b0;
                        frame_cnt_o <= frame_cnt_o + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
